// File: rtl/merger_output_writer.sv
// merger_output_writer
//   Write-back end of the merge sorter. Drains one sorted chunk from a
//   stream and writes it to working memory at consecutive addresses through
//   a single-cycle write port. Pulses done once the whole chunk is committed
//   and flags chunks whose tlast position disagrees with chunk_size.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   start                 one-cycle chunk request (only honoured in IDLE)
//   chunk_size            beats to write, clamped to MAX_SORT_LENGTH
//   chunk_base_address    first write address
//   input_data_*          stream slave: valid/ready/data/tlast
//   write_addr/data/enable registered single-cycle write port
//   busy                  high while a chunk is in WRITE or FINISH
//   done                  one-cycle completion pulse
//   length_error          sticky tlast/size mismatch, cleared by accepted start
module merger_output_writer #(
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_SORT_LENGTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [15:0]           chunk_size,
    input  logic [15:0]           chunk_base_address,
    input  logic                  input_data_valid,
    output logic                  input_data_ready,
    input  logic [DATA_WIDTH-1:0] input_data_data,
    input  logic                  input_data_tlast,
    output logic [15:0]           write_addr,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  write_enable,
    output logic                  busy,
    output logic                  done,
    output logic                  length_error
);

    localparam logic [15:0] MAX_LEN = 16'(MAX_SORT_LENGTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [15:0] base_q;
    logic [15:0] size_q;
    logic [15:0] count_q;
    logic [15:0] size_clamped;
    logic        handshake;
    logic        last_beat;
    logic        accept_start;

    assign size_clamped = (chunk_size > MAX_LEN) ? MAX_LEN : chunk_size;
    assign accept_start = (state == IDLE) && start;

    // ready is a pure state decode so it never combinationally depends on valid
    assign input_data_ready = (state == WRITE);
    assign busy             = (state != IDLE);
    assign handshake        = input_data_valid && input_data_ready;
    // Only evaluated in WRITE, where size_q is never zero
    assign last_beat        = (count_q == size_q - 16'd1);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = (size_clamped == 16'd0) ? FINISH : WRITE;
            WRITE:   if (handshake && last_beat) state_n = FINISH;
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            base_q       <= '0;
            size_q       <= '0;
            count_q      <= '0;
            write_addr   <= '0;
            write_data   <= '0;
            write_enable <= 1'b0;
            done         <= 1'b0;
            length_error <= 1'b0;
        end else begin
            write_enable <= handshake;
            // done trails FINISH by one cycle, i.e. one cycle after the last write
            done         <= (state == FINISH);
            if (accept_start) begin
                base_q       <= chunk_base_address;
                size_q       <= size_clamped;
                count_q      <= '0;
                length_error <= 1'b0;
            end
            if (handshake) begin
                write_addr <= base_q + count_q;  // wraps mod 2^16
                write_data <= input_data_data;
                count_q    <= count_q + 16'd1;
                // Early tlast and missing tlast both flag; the beat is still written
                if (input_data_tlast != last_beat) length_error <= 1'b1;
            end
        end
    end

endmodule
